// File: rtl/popcount05_unary_tx.sv
// Serial thermometer-code transmitter: each accepted count becomes a FRAME_LEN-beat frame with the ones sent first.
// Optional trailing parity beat when POPCOUNT_TX_PARITY_EN is defined.
module popcount05_unary_tx #(
  parameter int FRAME_LEN = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] in_count,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       sat_flag
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [2:0] FL = 3'(FRAME_LEN);
`ifdef POPCOUNT_TX_PARITY_EN
  localparam logic [2:0] LAST_BEAT = FL;
`else
  localparam logic [2:0] LAST_BEAT = FL - 3'd1;
`endif

  state_t     r_state, w_state_nxt;
  logic [2:0] r_ones_left, w_ones_left_nxt;
  logic [2:0] r_beat_cnt, w_beat_cnt_nxt;
  logic       r_sat, w_sat_nxt;
  logic       r_init_done;

  logic       w_in_fire;
  logic       w_out_fire;
  logic       w_data_bit;
  logic       w_last;
  logic       w_over;
  logic [2:0] w_clamped;

  assign w_over     = (in_count > FL);
  assign w_clamped  = w_over ? FL : in_count;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_data_bit = (r_ones_left != 3'd0);
  assign w_last     = (r_beat_cnt == LAST_BEAT);

  // in_ready stays low while reset is held and rises on the first edge after release.
  assign in_ready  = (r_state == IDLE) && r_init_done;
  assign out_valid = (r_state == SEND);
  assign out_last  = out_valid && w_last;
  assign sat_flag  = r_sat;

`ifdef POPCOUNT_TX_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (w_in_fire) begin
      r_parity <= w_clamped[0];
    end
  end

  assign out_bit = out_valid && (w_last ? r_parity : w_data_bit);
`else
  assign out_bit = out_valid && w_data_bit;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_ones_left_nxt = r_ones_left;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_sat_nxt       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_in_fire) begin
          w_state_nxt     = SEND;
          w_ones_left_nxt = w_clamped;
          w_beat_cnt_nxt  = 3'd0;
          w_sat_nxt       = w_over;
        end
      end
      SEND: begin
        if (w_out_fire) begin
          if (w_data_bit) begin
            w_ones_left_nxt = r_ones_left - 3'd1;
          end
          if (w_last) begin
            w_state_nxt    = IDLE;
            w_beat_cnt_nxt = 3'd0;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 3'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ones_left <= 3'd0;
      r_beat_cnt  <= 3'd0;
      r_sat       <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ones_left <= w_ones_left_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_sat       <= w_sat_nxt;
      r_init_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_popcount05_unary_tx.sv
// Scoreboard bench for popcount05_unary_tx (FRAME_LEN=5); honours POPCOUNT_TX_PARITY_EN.
module tb_popcount05_unary_tx;

  localparam int FL = 5;
`ifdef POPCOUNT_TX_PARITY_EN
  localparam int NB = FL + 1;
`else
  localparam int NB = FL;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] in_count;
  logic       in_valid;
  logic       in_ready;
  logic       out_bit;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       sat_flag;

  popcount05_unary_tx #(.FRAME_LEN(FL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_count (in_count),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_bit  (out_bit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .sat_flag (sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic last;
  } beat_t;

  beat_t exp_q[$];
  int    cnt_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  int    mon_idx = 0;
  int    mon_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-written frame bits, MSB is the first beat on the wire.
  task automatic push_frame(input logic [4:0] bits);
    beat_t bt;
    for (int i = 4; i >= 0; i--) begin
      bt.b = bits[i];
`ifdef POPCOUNT_TX_PARITY_EN
      bt.last = 1'b0;
`else
      bt.last = (i == 0);
`endif
      exp_q.push_back(bt);
    end
`ifdef POPCOUNT_TX_PARITY_EN
    bt.b    = ^bits;
    bt.last = 1'b1;
    exp_q.push_back(bt);
`endif
    cnt_q.push_back($countones(bits));
  endtask

  task automatic flush();
    exp_q.delete();
    cnt_q.delete();
    mon_idx = 0;
    mon_acc = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    check("idle_timeout", in_ready, 1);
  endtask

  task automatic send(input logic [2:0] cnt, input logic [4:0] bits, input logic sat);
    wait_idle();
    in_count = cnt;
    in_valid = 1'b1;
    push_frame(bits);
    step();
    in_valid = 1'b0;
    check("sat_flag", sat_flag, sat);
    check("in_ready_in_send", in_ready, 0);
    check("first_beat_latency", out_valid, 1);
  endtask

  // Monitor: compares every presented beat (also while stalled) and pops on accepted beats.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", out_valid, 0);
        end else begin
          check("out_bit", out_bit, exp_q[0].b);
          check("out_last", out_last, exp_q[0].last);
          if (out_ready) begin
            if (mon_idx < FL) mon_acc += int'(out_bit);
            mon_idx++;
            if (out_last) begin
              if (cnt_q.size() == 0) begin
                check("frame_without_count", 1, 0);
              end else begin
                check("frame_popcount", mon_acc, cnt_q[0]);
                void'(cnt_q.pop_front());
              end
              mon_idx = 0;
              mon_acc = 0;
            end
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [4:0] tbl_bits[8];
  logic       tbl_sat[8];
  logic [7:0] stall_pat;

  initial begin
    tbl_bits = '{5'b00000, 5'b10000, 5'b11000, 5'b11100,
                 5'b11110, 5'b11111, 5'b11111, 5'b11111};
    tbl_sat  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    stall_pat = 8'b1001_1011;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_count  = 3'd0;
    out_ready = 1'b1;

    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bit", out_bit, 0);
    check("rst_out_last", out_last, 0);
    check("rst_sat_flag", sat_flag, 0);
    step();
    step();
    check("rst_in_ready_clocked", in_ready, 0);
    #1 rst_n = 1'b1;
    step();
    check("in_ready_after_reset", in_ready, 1);

    // Count 3: 1,1,1,0,0; out_last on final beat, in_ready one cycle later.
    send(3'd3, 5'b11100, 1'b0);
    repeat (NB - 1) step();
    check("final_beat_last", out_last, 1);
    check("final_beat_in_ready", in_ready, 0);
    step();
    check("in_ready_after_frame", in_ready, 1);
    check("out_valid_after_frame", out_valid, 0);

    // Saturation: 7 clamps with a one-cycle pulse, 5 does not.
    send(3'd7, 5'b11111, 1'b1);
    step();
    check("sat_pulse_one_cycle", sat_flag, 0);
    send(3'd5, 5'b11111, 1'b0);

    // in_valid during SEND is ignored.
    send(3'd1, 5'b10000, 1'b0);
    in_count = 3'd7;
    in_valid = 1'b1;
    step();
    step();
    check("sat_ignored_in_send", sat_flag, 0);
    in_valid = 1'b0;

    // Backpressure: ready pattern 1,0,0,1,1,0,1,1.
    send(3'd2, 5'b11000, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      out_ready = stall_pat[i];
      step();
    end
    out_ready = 1'b1;
    wait_idle();

    // Reset after beat 2 of count 4 aborts the frame.
    send(3'd4, 5'b11110, 1'b0);
    step();
    step();
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_bit", out_bit, 0);
    check("abort_out_last", out_last, 0);
    check("abort_in_ready", in_ready, 0);
    flush();
    step();
    check("abort_held_out_valid", out_valid, 0);
    #1 rst_n = 1'b1;
    step();
    check("in_ready_after_abort", in_ready, 1);
    send(3'd1, 5'b10000, 1'b0);

    // Every count, back to back.
    for (int c = 0; c < 8; c++) begin
      send(3'(c), tbl_bits[c], tbl_sat[c]);
    end
    wait_idle();
    repeat (3) step();
    check("scoreboard_drained", exp_q.size(), 0);
    check("counts_drained", cnt_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/popcount05_unary_tx.md
POPCOUNT05_UNARY_TX -- requirements
Module: popcount05_unary_tx

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 5: data beats per frame, legal range 1..7.
REQ-002 The block SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_count, input, 3: requested number of ones in the frame, unsigned.
REQ-005 The block SHALL have port in_valid, input, 1: in_count is valid.
REQ-006 The block SHALL have port in_ready, output, 1: block can accept in_count.
REQ-007 The block SHALL have port out_bit, output, 1: serial frame bit.
REQ-008 The block SHALL have port out_valid, output, 1: out_bit is valid.
REQ-009 The block SHALL have port out_ready, input, 1: downstream accepts out_bit.
REQ-010 The block SHALL have port out_last, output, 1: current beat is the final beat of the frame.
REQ-011 The block SHALL have port sat_flag, output, 1: one-cycle pulse flagging a clamped request.

Function
REQ-012 The block SHALL emit a serial frame whose popcount equals the accepted count, so that a downstream popcount of FRAME_LEN bits recovers the count.
REQ-013 The block SHALL implement exactly two states: IDLE and SEND.
REQ-014 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-015 In SEND, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-016 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-017 On an input transfer, the block SHALL latch min(in_count, FRAME_LEN) into ones_left, clear beat_cnt to 0, and enter SEND.
REQ-018 On an input transfer with in_count > FRAME_LEN, sat_flag SHALL be 1 for exactly the next cycle; otherwise sat_flag SHALL be 0.
REQ-019 The frame SHALL be thermometer coded: out_bit = 1 while ones_left != 0, else 0; ones are sent first.
REQ-020 An output beat SHALL complete only on an edge with out_valid=1 and out_ready=1.
REQ-021 On each completed beat, ones_left SHALL decrement if out_bit=1, and beat_cnt SHALL increment.
REQ-022 While out_ready=0, out_bit, out_last and all state SHALL hold unchanged.
REQ-023 out_last SHALL be 1 only during the final beat of the frame.
REQ-024 Completion of the final beat SHALL return the block to IDLE.
REQ-025 in_ready SHALL rise the cycle after the final beat completes, giving exactly one idle bubble between back-to-back frames.
REQ-026 Latency from input transfer to the first valid beat SHALL be 1 cycle; with out_ready held at 1, a frame SHALL take FRAME_LEN cycles (FRAME_LEN+1 with parity enabled).
REQ-027 in_count=0 SHALL produce a frame of all zeros.
REQ-028 in_valid asserted during SEND SHALL be ignored and SHALL NOT alter the frame in flight.

Reset
REQ-029 While rst_n=0, the block SHALL force: state IDLE, ones_left 0, beat_cnt 0, out_valid 0, out_bit 0, out_last 0, sat_flag 0, in_ready 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately with no further beats; the aborted frame SHALL NOT resume.
REQ-031 in_ready SHALL be 1 from the first clock edge after rst_n deasserts.

Configuration
REQ-032 Macro POPCOUNT_TX_PARITY_EN SHALL control an optional parity beat.
REQ-033 With POPCOUNT_TX_PARITY_EN defined, the frame SHALL carry one extra beat after the FRAME_LEN data beats: out_bit = XOR of the data bits (the LSB of the clamped count), with out_last on that beat only.
REQ-034 Without POPCOUNT_TX_PARITY_EN, the frame SHALL be FRAME_LEN beats and the parity logic SHALL be absent.

Verification
REQ-035 in_count=3, out_ready=1, FRAME_LEN=5 -> out_bit 1,1,1,0,0 over 5 cycles; out_last on beat 5; in_ready high 1 cycle later.
REQ-036 in_count=7 -> frame 1,1,1,1,1; sat_flag pulses 1 cycle after the transfer; in_count=5 -> no sat_flag.
REQ-037 in_count=2, out_ready toggling 1,0,0,1,1,0,1,1 -> bits 1,1,0,0,0 delivered unchanged across stalls; out_last held while stalled.
REQ-038 Reset pulsed after beat 2 of in_count=4 -> out_valid=0 immediately; the next in_count=1 yields 1,0,0,0,0.
REQ-039 POPCOUNT_TX_PARITY_EN defined, in_count=3 -> 1,1,1,0,0 then parity 1 with out_last; in_count=4 -> parity 0.
REQ-040 Randomized counts 0..7 through a reference 5-bit popcount on the output frames -> each recovered count equals min(in_count,5).
